prog_loader: RTL

- Writer side of the program RAM: receives a byte stream, assembles 16-bit instruction words, and writes them into the 16x128 program RAM through its write port.
- The processor only reads that RAM, fetching through pc/ram_read_en.
- Releases the processor by asserting start once a complete, checksum-verified image is in RAM.
- Sits between the host/serial front end and the program RAM plus proc start input.

---
 rtl/prog_loader.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Writer side of the processor's program RAM. Receives a byte stream from the
// host/serial front end, assembles 16-bit words (high byte first), writes the
// image into the program RAM and releases the processor via `start` once the
// whole image has been checked against its trailing checksum.
//
// Stream: header word N (1..MAX_WORDS), N data words, checksum word equal to
// the 16-bit wrap-around sum of the data words.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   load_req      single-cycle pulse, begins a new image load when not busy
//   byte_valid    byte_data holds a valid byte
//   byte_data     incoming stream byte
//   byte_ready    loader accepts a byte (transfer on byte_valid & byte_ready)
//   ram_write_en  one-cycle program RAM write strobe
//   ram_addr      program RAM write address (held between strobes)
//   ram_din       program RAM write data (held between strobes)
//   start         high while a verified image sits in RAM
//   busy          high in any receive state
//   error         high when the last load failed
//   words_loaded  data words written in the current/last load
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_WIDTH = 7,
    parameter int MAX_WORDS  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_req,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_din,
    output logic                  start,
    output logic                  busy,
    output logic                  error,
    output logic [7:0]            words_loaded
);

    // One extra bit so that N == 2**ADDR_WIDTH is representable.
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_COUNT,
        S_RX_DATA,
        S_RX_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t                state_q,   state_d;
    logic                  phase_q,   phase_d;   // 0: expecting high byte
    logic [7:0]            hi_q,      hi_d;      // latched high byte
    logic [CNT_W-1:0]      count_q,   count_d;   // N from the header
    logic [ADDR_WIDTH-1:0] index_q,   index_d;   // next RAM address to write
    logic [15:0]           csum_q,    csum_d;    // running sum of data words
    logic [7:0]            words_q,   words_d;
    logic                  we_q,      we_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [15:0]           din_q,     din_d;

    // -------------------------------------------------------------------------
    // Handshake and word assembly helpers
    // -------------------------------------------------------------------------
    logic        accept;      // a byte is transferred this cycle
    logic        word_done;   // the accepted byte is the low byte of a word
    logic [15:0] word_w;      // the word completed this cycle
    logic        restart;     // load_req honoured (only outside receive states)
    logic        hdr_bad;     // header N outside 1..MAX_WORDS
    logic        last_word;   // the data word being completed is word N-1

    always_comb begin
        accept    = byte_valid & byte_ready;
        word_done = accept & phase_q;
        word_w    = {hi_q, byte_data};
        restart   = load_req & ((state_q == S_IDLE) ||
                                (state_q == S_DONE) ||
                                (state_q == S_ERROR));
        hdr_bad   = (word_w == 16'd0) || (word_w > 16'(MAX_WORDS));
        // Compare in CNT_W bits: index wraps to 0 after the 2**ADDR_WIDTH-th
        // word, but this comparison sees index+1 == N first and leaves RX_DATA.
        last_word = (({1'b0, index_q} + CNT_W'(1)) == count_q);
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (restart) begin
                    state_d = S_RX_COUNT;
                end
            end
            S_RX_COUNT: begin
                if (word_done) begin
                    state_d = hdr_bad ? S_ERROR : S_RX_DATA;
                end
            end
            S_RX_DATA: begin
                if (word_done && last_word) begin
                    state_d = S_RX_CSUM;
                end
            end
            S_RX_CSUM: begin
                if (word_done) begin
                    state_d = (word_w == csum_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state-decoded outputs. start/error come straight from registered
    // state, so start rises the cycle after the final checksum byte.
    // -------------------------------------------------------------------------
    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        start      = 1'b0;
        error      = 1'b0;
        unique case (state_q)
            S_RX_COUNT, S_RX_DATA, S_RX_CSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            S_DONE:  start = 1'b1;
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        count_d = count_q;
        index_d = index_q;
        csum_d  = csum_q;
        words_d = words_q;
        we_d    = 1'b0;      // strobe is a single-cycle pulse
        addr_d  = addr_q;    // address/data hold between strobes
        din_d   = din_q;

        if (restart) begin
            phase_d = 1'b0;
            index_d = '0;
            csum_d  = '0;
            words_d = '0;
        end else if (accept) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = byte_data;
            end
            if (word_done) begin
                unique case (state_q)
                    S_RX_COUNT: begin
                        count_d = word_w[CNT_W-1:0];
                    end
                    S_RX_DATA: begin
                        // Registered write: the strobe appears exactly one
                        // cycle after the low-byte handshake.
                        we_d    = 1'b1;
                        addr_d  = index_q;
                        din_d   = word_w;
                        csum_d  = csum_q + word_w;
                        index_d = index_q + ADDR_WIDTH'(1);
                        words_d = words_q + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers. The program RAM itself lives outside this block and
    // is deliberately not cleared on reset; only the loader's own state is.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
            count_q <= '0;
            index_q <= '0;
            csum_q  <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
            count_q <= count_d;
            index_q <= index_d;
            csum_q  <= csum_d;
            words_q <= words_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign ram_write_en = we_q;
    assign ram_addr     = addr_q;
    assign ram_din      = din_q;
    assign words_loaded = words_q;

endmodule
